// File: rtl/clk_div_pkg.sv
// Shared clock-divider constants: board clock, display rate and the default divide ratio.
package clk_div_pkg;

    localparam int SYS_CLK_HZ = 50_000_000;
    localparam int DISP_HZ    = 1;

    function automatic int div_from_hz(input int sys_hz, input int out_hz);
        return sys_hz / out_hz;
    endfunction

    localparam int DIV_DEFAULT = div_from_hz(SYS_CLK_HZ, DISP_HZ);

endpackage

// File: rtl/clk_for_d0_cnt.sv
// Modulo-DIV wrap counter with enable; exposes both the registered count and its next value.
module clk_for_d0_cnt #(
    parameter int DIV   = 4,
    parameter int CNT_W = $clog2(DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_next
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_next = cnt;
        if (en) begin
            cnt_next = (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/clk_for_d0_div.sv
// Registered clock divider: o is low for LO_CYC enabled cycles, then high for HI_CYC.
// Optional one-cycle rise pulse o_tick is built when CLK_FOR_D0_DIV_TICK_EN is defined.
module clk_for_d0_div
    import clk_div_pkg::*;
#(
    parameter int DIV   = DIV_DEFAULT,
    parameter int CNT_W = $clog2(DIV)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic o
`ifdef CLK_FOR_D0_DIV_TICK_EN
    ,
    output logic o_tick
`endif
);

    localparam int HI_CYC = DIV / 2;
    localparam int LO_CYC = DIV - HI_CYC;
    localparam logic [CNT_W-1:0] LO_THR = CNT_W'(LO_CYC);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("clk_for_d0_div: DIV must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    clk_for_d0_cnt #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .cnt      (cnt),
        .cnt_next (cnt_next)
    );

    // Compare against the next count so o moves on the same edge the counter crosses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o <= 1'b0;
        end else if (en) begin
            o <= (cnt_next >= LO_THR);
        end
    end

`ifdef CLK_FOR_D0_DIV_TICK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_tick <= 1'b0;
        end else begin
            o_tick <= en & (cnt_next == LO_THR);
        end
    end
`endif

endmodule

// File: tb/tb_clk_for_d0_div.sv
// Self-checking bench for clk_for_d0_div at small DIV values (2, 4, 5, 6); tick checks
// are compiled in when CLK_FOR_D0_DIV_TICK_EN is defined.
module tb_clk_for_d0_div;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic o2, o4, o5, o6;
`ifdef CLK_FOR_D0_DIV_TICK_EN
    logic t2, t4, t5, t6;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];
    bit exp_t_q[$];

    always #5 clk = ~clk;

`ifdef CLK_FOR_D0_DIV_TICK_EN
    clk_for_d0_div #(.DIV(2)) dut2 (.clk(clk), .rst_n(rst_n), .en(en), .o(o2), .o_tick(t2));
    clk_for_d0_div #(.DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .en(en), .o(o4), .o_tick(t4));
    clk_for_d0_div #(.DIV(5)) dut5 (.clk(clk), .rst_n(rst_n), .en(en), .o(o5), .o_tick(t5));
    clk_for_d0_div #(.DIV(6)) dut6 (.clk(clk), .rst_n(rst_n), .en(en), .o(o6), .o_tick(t6));
`else
    clk_for_d0_div #(.DIV(2)) dut2 (.clk(clk), .rst_n(rst_n), .en(en), .o(o2));
    clk_for_d0_div #(.DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .en(en), .o(o4));
    clk_for_d0_div #(.DIV(5)) dut5 (.clk(clk), .rst_n(rst_n), .en(en), .o(o5));
    clk_for_d0_div #(.DIV(6)) dut6 (.clk(clk), .rst_n(rst_n), .en(en), .o(o6));
`endif

    // Reference: after k enabled edges the phase is k mod div; o is high in the last div/2 phases.
    function automatic bit ref_o(input int div, input int k);
        return (k % div) >= (div - div / 2);
    endfunction

    function automatic bit ref_tick(input int div, input int k);
        return (k > 0) && ((k % div) == (div - div / 2));
    endfunction

    task automatic restart(input bit en_val);
        @(negedge clk);
        rst_n = 1'b0;
        en    = en_val;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        bit exp;
        rst_n = 1'b0;
        en    = 1'b1;
        #13;
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        exp = exp_q.pop_front(); n_checks++;
        if (o2 !== exp) begin n_fail++; $display("FAIL reset_o2: got %b want %b", o2, exp); end
        exp = exp_q.pop_front(); n_checks++;
        if (o4 !== exp) begin n_fail++; $display("FAIL reset_o4: got %b want %b", o4, exp); end
        exp = exp_q.pop_front(); n_checks++;
        if (o5 !== exp) begin n_fail++; $display("FAIL reset_o5: got %b want %b", o5, exp); end
        exp = exp_q.pop_front(); n_checks++;
        if (o6 !== exp) begin n_fail++; $display("FAIL reset_o6: got %b want %b", o6, exp); end
`ifdef CLK_FOR_D0_DIV_TICK_EN
        exp_t_q.push_back(1'b0);
        exp = exp_t_q.pop_front(); n_checks++;
        if (t4 !== exp) begin n_fail++; $display("FAIL reset_tick4: got %b want %b", t4, exp); end
`endif
    endtask

    task automatic test_div4;
        bit exp;
        restart(1'b1);
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back(ref_o(4, k));
            @(posedge clk); #1;
            exp = exp_q.pop_front(); n_checks++;
            if (o4 !== exp) begin n_fail++; $display("FAIL div4_edge%0d: got %b want %b", k, o4, exp); end
        end
    endtask

    task automatic test_div5;
        bit exp;
        restart(1'b1);
        for (int k = 1; k <= 10; k++) begin
            exp_q.push_back(ref_o(5, k));
            @(posedge clk); #1;
            exp = exp_q.pop_front(); n_checks++;
            if (o5 !== exp) begin n_fail++; $display("FAIL div5_edge%0d: got %b want %b", k, o5, exp); end
        end
    endtask

    task automatic test_freeze;
        bit exp;
        int k;
        restart(1'b1);
        k = 0;
        for (int i = 0; i < 2; i++) begin
            k++;
            exp_q.push_back(ref_o(4, k));
            @(posedge clk); #1;
            exp = exp_q.pop_front(); n_checks++;
            if (o4 !== exp) begin n_fail++; $display("FAIL freeze_pre%0d: got %b want %b", k, o4, exp); end
        end
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ref_o(4, k));
            @(posedge clk); #1;
            exp = exp_q.pop_front(); n_checks++;
            if (o4 !== exp) begin n_fail++; $display("FAIL freeze_hold%0d: got %b want %b", i, o4, exp); end
        end
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            k++;
            exp_q.push_back(ref_o(4, k));
            @(posedge clk); #1;
            exp = exp_q.pop_front(); n_checks++;
            if (o4 !== exp) begin n_fail++; $display("FAIL freeze_resume%0d: got %b want %b", k, o4, exp); end
        end
    endtask

    task automatic test_async_reset;
        bit exp;
        restart(1'b1);
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(ref_o(6, k));
            @(posedge clk); #1;
            exp = exp_q.pop_front(); n_checks++;
            if (o6 !== exp) begin n_fail++; $display("FAIL arst_pre%0d: got %b want %b", k, o6, exp); end
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(1'b0);
        exp = exp_q.pop_front(); n_checks++;
        if (o6 !== exp) begin n_fail++; $display("FAIL arst_immediate: got %b want %b", o6, exp); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            exp_q.push_back(ref_o(6, k));
            @(posedge clk); #1;
            exp = exp_q.pop_front(); n_checks++;
            if (o6 !== exp) begin n_fail++; $display("FAIL arst_post%0d: got %b want %b", k, o6, exp); end
        end
    endtask

`ifdef CLK_FOR_D0_DIV_TICK_EN
    task automatic test_tick;
        bit exp;
        restart(1'b1);
        for (int k = 1; k <= 10; k++) begin
            exp_t_q.push_back(ref_tick(4, k));
            @(posedge clk); #1;
            exp = exp_t_q.pop_front(); n_checks++;
            if (t4 !== exp) begin n_fail++; $display("FAIL tick_edge%0d: got %b want %b", k, t4, exp); end
        end
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_t_q.push_back(1'b0);
            @(posedge clk); #1;
            exp = exp_t_q.pop_front(); n_checks++;
            if (t4 !== exp) begin n_fail++; $display("FAIL tick_disabled%0d: got %b want %b", i, t4, exp); end
        end
    endtask
`endif

    task automatic test_div2;
        bit exp;
        restart(1'b1);
        for (int k = 1; k <= 6; k++) begin
            exp_q.push_back(ref_o(2, k));
            @(posedge clk); #1;
            exp = exp_q.pop_front(); n_checks++;
            if (o2 !== exp) begin n_fail++; $display("FAIL div2_edge%0d: got %b want %b", k, o2, exp); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_div4();
        test_div5();
        test_freeze();
        test_async_reset();
`ifdef CLK_FOR_D0_DIV_TICK_EN
        test_tick();
`endif
        test_div2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
